deadlock_confirm_reporter: RTL and testbench

Sits directly downstream of the per-instance deadlock monitor in the co-simulation testbench. It consumes the monitor's one-cycle-granular `block` flag and `axis_block_info` vector and debounces them with a persistence counter. Once a blockage has held for a configured number of cycles, it latches a snapshot, offers a single report record over a valid/ready handshake, and requests simulation stop. It filters transient back-pressure stalls so that only sustained deadlocks end the run.

---
 rtl/deadlock_confirm_reporter.sv | 157 +++++++++++++++
 tb/tb_deadlock_confirm_reporter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/deadlock_confirm_reporter.sv
// Debounces the deadlock monitor's block flag and, once a blockage persists for
// CONFIRM_CYCLES samples, offers one report record and then requests simulation stop.
// Optional macro DEADLOCK_SNAPSHOT_CHECK_EN restarts the count whenever the blocked channel set changes.
module deadlock_confirm_reporter #(
  parameter int AXIS_W         = 4,
  parameter int CONFIRM_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block,
  input  logic [AXIS_W-1:0] axis_block_info,
  input  logic              clear,
  output logic              report_valid,
  input  logic              report_ready,
  output logic [AXIS_W-1:0] report_info,
  output logic [CNT_W-1:0]  report_cycles,
  output logic [CNT_W-1:0]  suspect_cnt,
  output logic              deadlock_found,
  output logic              stop_sim
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SUSPECT = 2'd1,
    S_REPORT  = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CONF_CNT    = CNT_W'(CONFIRM_CYCLES);
  localparam logic [CNT_W-1:0] CONF_CNT_M1 = CNT_W'(CONFIRM_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AXIS_W-1:0]   snap_q, snap_d;
  logic                valid_q, valid_d;
  logic                stop_q, stop_d;
  logic                found_q, found_d;
  logic [AXIS_W-1:0]   info_q, info_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      snap_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (block) begin
            snap_d = axis_block_info;
            if (CONFIRM_CYCLES == 1) begin
              state_d = S_REPORT;
              cnt_d   = CONF_CNT;
            end else begin
              state_d = S_SUSPECT;
              cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            cnt_d = '0;
          end
        end
        S_SUSPECT: begin
          if (!block) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            snap_d  = '0;
          end else begin
            // Confirmation is judged on the pre-restart count; a moved channel set only restarts otherwise.
            if (cnt_q == CONF_CNT_M1) begin
              state_d = S_REPORT;
              cnt_d   = CONF_CNT;
            end else begin
              cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
`ifdef DEADLOCK_SNAPSHOT_CHECK_EN
            if (axis_block_info != snap_q) begin
              snap_d = axis_block_info;
              if (cnt_q != CONF_CNT_M1) begin
                cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
              end else begin
                cnt_d = CONF_CNT;
              end
            end else begin
              snap_d = snap_q;
            end
`else
            snap_d = snap_q;
`endif
          end
        end
        S_REPORT: begin
          if (valid_q && report_ready) begin
            state_d = S_HALT;
          end else begin
            state_d = S_REPORT;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          snap_d  = '0;
        end
      endcase
    end
  end

  // Output flops are loaded from next-state so they line up with the state register.
  always_comb begin
    valid_d  = (state_d == S_REPORT);
    stop_d   = (state_d == S_HALT);
    found_d  = (state_d == S_REPORT) || (state_d == S_HALT);
    if (found_d) begin
      info_d   = snap_d;
      cycles_d = cnt_d;
    end else begin
      info_d   = '0;
      cycles_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      snap_q   <= '0;
      valid_q  <= 1'b0;
      stop_q   <= 1'b0;
      found_q  <= 1'b0;
      info_q   <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      valid_q  <= valid_d;
      stop_q   <= stop_d;
      found_q  <= found_d;
      info_q   <= info_d;
      cycles_q <= cycles_d;
    end
  end

  assign report_valid   = valid_q;
  assign stop_sim       = stop_q;
  assign deadlock_found = found_q;
  assign report_info    = info_q;
  assign report_cycles  = cycles_q;
  assign suspect_cnt    = cnt_q;

endmodule

// File: tb/tb_deadlock_confirm_reporter.sv
// Directed, table-driven bench for deadlock_confirm_reporter with CONFIRM_CYCLES=8.
module tb_deadlock_confirm_reporter;

  localparam int AW = 4;
  localparam int CW = 16;
  localparam int CC = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          block;
  logic [AW-1:0] axis_block_info;
  logic          clear;
  logic          report_ready;
  logic          report_valid;
  logic [AW-1:0] report_info;
  logic [CW-1:0] report_cycles;
  logic [CW-1:0] suspect_cnt;
  logic          deadlock_found;
  logic          stop_sim;

  deadlock_confirm_reporter #(
    .AXIS_W(AW), .CONFIRM_CYCLES(CC), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .block(block), .axis_block_info(axis_block_info),
    .clear(clear), .report_valid(report_valid), .report_ready(report_ready),
    .report_info(report_info), .report_cycles(report_cycles), .suspect_cnt(suspect_cnt),
    .deadlock_found(deadlock_found), .stop_sim(stop_sim)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic          blk;
    logic [AW-1:0] inf;
    logic          clr;
    logic          rdy;
    logic          ev;
    logic          es;
    logic [CW-1:0] ec;
    logic [AW-1:0] ei;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic es,
                         input logic [CW-1:0] ec, input logic [AW-1:0] ei);
    logic          ef;
    logic [CW-1:0] ecy;
    ef  = ev | es;
    ecy = ef ? CW'(CC) : '0;
    chk({tag, ".valid"},  {31'd0, report_valid},   {31'd0, ev});
    chk({tag, ".stop"},   {31'd0, stop_sim},       {31'd0, es});
    chk({tag, ".found"},  {31'd0, deadlock_found}, {31'd0, ef});
    chk({tag, ".cnt"},    {16'd0, suspect_cnt},    {16'd0, ec});
    chk({tag, ".info"},   {28'd0, report_info},    {28'd0, ei});
    chk({tag, ".cycles"}, {16'd0, report_cycles},  {16'd0, ecy});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic void add(input logic b, input logic [AW-1:0] i, input logic c, input logic r,
                              input logic ev, input logic es, input logic [CW-1:0] ec,
                              input logic [AW-1:0] ei);
    vec_t v;
    v.blk = b; v.inf = i; v.clr = c; v.rdy = r;
    v.ev = ev; v.es = es; v.ec = ec; v.ei = ei;
    tbl.push_back(v);
  endfunction

  initial begin
    // Test 1: sustained block with info E confirms after 8 samples.
    for (int k = 1; k <= 7; k++) add(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 16'(k), 4'h0);
    add(1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8, 4'hE);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8, 4'hE);
    add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd8, 4'hE);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd8, 4'hE);
    add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 4'h0);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'h0);
    // Test 2: 5 high, 1 low gap, then 8 high.
    for (int k = 1; k <= 5; k++) add(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 16'(k), 4'h0);
    add(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'h0);
    for (int k = 1; k <= 7; k++) add(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 16'(k), 4'h0);
    add(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8, 4'h3);
    add(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 16'd8, 4'h3);
    add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 4'h0);

    reset = 1'b1; block = 1'b0; clear = 1'b0; report_ready = 1'b0; axis_block_info = '0;
    #12;
    chk_out("reset", 1'b0, 1'b0, 16'd0, 4'h0);
    reset = 1'b0;

    for (int n = 0; n < tbl.size(); n++) begin
      block = tbl[n].blk; axis_block_info = tbl[n].inf;
      clear = tbl[n].clr; report_ready = tbl[n].rdy;
      step();
      chk_out($sformatf("vec%0d", n), tbl[n].ev, tbl[n].es, tbl[n].ec, tbl[n].ei);
    end
    clear = 1'b0; report_ready = 1'b0;

    // Test 5: asynchronous reset at count 5, mid-cycle.
    block = 1'b1; axis_block_info = 4'h7;
    repeat (5) step();
    chk("t5.cnt5", {16'd0, suspect_cnt}, 32'd5);
    #3 reset = 1'b1;
    #1 chk_out("t5.async", 1'b0, 1'b0, 16'd0, 4'h0);
    #2 reset = 1'b0;
    step();
    chk("t5.restart", {16'd0, suspect_cnt}, 32'd1);
    block = 1'b0;
    step();
    chk("t5.idle", {16'd0, suspect_cnt}, 32'd0);

    // Test 3: hold ready low 10 cycles, then handshake, then stop held 20 cycles.
    block = 1'b1; axis_block_info = 4'h5;
    repeat (8) step();
    chk_out("t3.rise", 1'b1, 1'b0, 16'd8, 4'h5);
    block = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_out($sformatf("t3.wait%0d", k), 1'b1, 1'b0, 16'd8, 4'h5);
    end
    report_ready = 1'b1;
    step();
    chk_out("t3.hs", 1'b0, 1'b1, 16'd8, 4'h5);
    report_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("t3.stop%0d", k), {31'd0, stop_sim}, 32'd1);
    end
    clear = 1'b1;
    step();
    chk_out("t4.clr_halt", 1'b0, 1'b0, 16'd0, 4'h0);
    clear = 1'b0;

    // Ready already high before valid: handshake on the first REPORT cycle.
    report_ready = 1'b1; block = 1'b1; axis_block_info = 4'h9;
    repeat (7) step();
    chk_out("early.pre", 1'b0, 1'b0, 16'd7, 4'h0);
    step();
    chk_out("early.valid", 1'b1, 1'b0, 16'd8, 4'h9);
    step();
    chk_out("early.halt", 1'b0, 1'b1, 16'd8, 4'h9);
    report_ready = 1'b0; block = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;

    // Test 4b: clear and handshake in the same cycle; clear wins.
    block = 1'b1; axis_block_info = 4'h2;
    repeat (8) step();
    chk_out("t4.report", 1'b1, 1'b0, 16'd8, 4'h2);
    clear = 1'b1; report_ready = 1'b1; block = 1'b0;
    step();
    chk_out("t4.clr_hs", 1'b0, 1'b0, 16'd0, 4'h0);
    clear = 1'b0; report_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t4.nostop%0d", k), {31'd0, stop_sim}, 32'd0);
    end

    // Test 6: info moves from E to B after count 6.
    block = 1'b1; axis_block_info = 4'hE;
    repeat (6) step();
    chk("t6.cnt6", {16'd0, suspect_cnt}, 32'd6);
    axis_block_info = 4'hB;
    step();
`ifdef DEADLOCK_SNAPSHOT_CHECK_EN
    chk("t6.restart", {16'd0, suspect_cnt}, 32'd1);
    repeat (6) step();
    chk_out("t6.pre", 1'b0, 1'b0, 16'd7, 4'h0);
    step();
    chk_out("t6.report", 1'b1, 1'b0, 16'd8, 4'hB);
`else
    chk("t6.cnt7", {16'd0, suspect_cnt}, 32'd7);
    step();
    chk_out("t6.report", 1'b1, 1'b0, 16'd8, 4'hE);
`endif
    block = 1'b0; clear = 1'b1;
    step();
    chk_out("t6.clear", 1'b0, 1'b0, 16'd0, 4'h0);
    clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
